krnl_partialknn_local_sp_2p_mem: RTL and testbench

Parametrised simple-dual-port local scratchpad for the partialKnn kernel wrappers: one write port, one read port, configurable read latency, byte-granular writes and defined read-during-write behaviour. It replaces the single-port URAM scratchpad wrappers so the distance stage can stream writes while the top-K stage reads. Read data is tagged with a valid strobe, so consumers need no latency counters.

---
 rtl/krnl_partialknn_mem_pkg.sv | 27 ++
 rtl/krnl_partialknn_rd_pipe.sv | 48 ++++
 rtl/krnl_partialknn_local_sp_2p_mem.sv | 104 ++++++++++
 tb/tb_krnl_partialknn_local_sp_2p_mem.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_partialknn_mem_pkg.sv
// Shared constants and helpers for the partialKnn local scratchpad memories.
// Latency bounds, collision modes and the byte-lane merge used by the bypass path.
package krnl_partialknn_mem_pkg;

   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 4;

   // Same-edge read/write collision result selection.
   localparam int BYPASS_OLD_DATA = 0;
   localparam int BYPASS_NEW_DATA = 1;

   localparam int BYTE_BITS = 8;

   function automatic int byte_lanes(input int data_width);
      return data_width / BYTE_BITS;
   endfunction

   // One lane of the old/new word merge: enabled lanes take the incoming byte.
   function automatic logic [BYTE_BITS-1:0] merge_byte(
      input logic [BYTE_BITS-1:0] old_byte,
      input logic [BYTE_BITS-1:0] new_byte,
      input logic                 lane_en
   );
      return lane_en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/krnl_partialknn_rd_pipe.sv
// Read-data delay line of {valid, data} stages with asynchronous active-low clear.
// Each data stage only loads when the stage feeding it is valid, so the tail holds the last read.
module krnl_partialknn_rd_pipe #(
   parameter int Depth = 1,
   parameter int Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [Width-1:0] in_data,
   output logic             out_valid,
   output logic [Width-1:0] out_data
);

   generate
      if (Depth == 0) begin : g_passthru
         assign out_valid = in_valid;
         assign out_data  = in_data;
      end else begin : g_stages
         logic             valid_reg [Depth];
         logic [Width-1:0] data_reg  [Depth];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < Depth; i++) begin
                  valid_reg[i] <= 1'b0;
                  data_reg[i]  <= '0;
               end
            end else begin
               valid_reg[0] <= in_valid;
               if (in_valid) begin
                  data_reg[0] <= in_data;
               end
               for (int i = 1; i < Depth; i++) begin
                  valid_reg[i] <= valid_reg[i-1];
                  if (valid_reg[i-1]) begin
                     data_reg[i] <= data_reg[i-1];
                  end
               end
            end
         end

         assign out_valid = valid_reg[Depth-1];
         assign out_data  = data_reg[Depth-1];
      end
   endgenerate

endmodule

// File: rtl/krnl_partialknn_local_sp_2p_mem.sv
// Simple-dual-port local scratchpad: one byte-masked write port, one pipelined read port
// with a valid strobe and selectable same-edge read-during-write behaviour.
module krnl_partialknn_local_sp_2p_mem
   import krnl_partialknn_mem_pkg::*;
#(
   parameter int DataWidth    = 256,
   parameter int AddressRange = 2048,
   parameter int AddressWidth = 11,
   parameter int ReadLatency  = 2,
   parameter int Bypass       = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [AddressWidth-1:0]   address0,
   input  logic                      ce0,
   output logic [DataWidth-1:0]      q0,
   output logic                      q0_valid,
   input  logic [AddressWidth-1:0]   address1,
   input  logic [DataWidth/8-1:0]    we1,
   input  logic [DataWidth-1:0]      d1
);

   localparam int Lanes = byte_lanes(DataWidth);
   // Latencies outside the supported window are pulled to the nearest bound.
   localparam int Latency = (ReadLatency < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                            (ReadLatency > MAX_READ_LATENCY) ? MAX_READ_LATENCY : ReadLatency;
   localparam int IndexWidth = (AddressRange > 1) ? $clog2(AddressRange) : 1;
   localparam logic [AddressWidth:0] AddrLimit = (AddressWidth+1)'(AddressRange);

   (* ram_style = "ultra" *) logic [DataWidth-1:0] mem [AddressRange];

   logic [IndexWidth-1:0] rd_idx;
   logic [IndexWidth-1:0] wr_idx;
   logic                  rd_in_range;
   logic                  wr_issue;
   logic                  wr_fire;
   logic                  collide;
   logic [DataWidth-1:0]  old_word;
   logic [DataWidth-1:0]  merged_word;
   logic [DataWidth-1:0]  rd_next;
   logic                  rd_valid_reg;
   logic [DataWidth-1:0]  rd_data_reg;

   assign rd_idx      = address0[IndexWidth-1:0];
   assign wr_idx      = address1[IndexWidth-1:0];
   assign rd_in_range = ({1'b0, address0} < AddrLimit);
   assign wr_issue    = (|we1) && ({1'b0, address1} < AddrLimit);
   // Writes are suppressed for as long as the reset input is held low.
   assign wr_fire     = reset && wr_issue;
   assign collide     = wr_issue && (address0 == address1);
   assign old_word    = mem[rd_idx];

   generate
      for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
         assign merged_word[gi*BYTE_BITS +: BYTE_BITS] =
            merge_byte(old_word[gi*BYTE_BITS +: BYTE_BITS], d1[gi*BYTE_BITS +: BYTE_BITS], we1[gi]);
      end
   endgenerate

   always_comb begin
      rd_next = old_word;
      if (!rd_in_range) begin
         rd_next = '0;
      end else if (collide && (Bypass == BYPASS_NEW_DATA)) begin
         rd_next = merged_word;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < Lanes; i++) begin
            if (we1[i]) begin
               mem[wr_idx][i*BYTE_BITS +: BYTE_BITS] <= d1[i*BYTE_BITS +: BYTE_BITS];
            end
         end
      end
   end

   // Array output register: first of the Latency read stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= ce0;
         if (ce0) begin
            rd_data_reg <= rd_next;
         end
      end
   end

   krnl_partialknn_rd_pipe #(
      .Depth (Latency - 1),
      .Width (DataWidth)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_valid_reg),
      .in_data   (rd_data_reg),
      .out_valid (q0_valid),
      .out_data  (q0)
   );

endmodule

// File: tb/tb_krnl_partialknn_local_sp_2p_mem.sv
// Drives four scratchpad instances (latency 1..4, both collision modes, one short range)
// from shared stimulus and compares each against a queue-based reference model.
module tb_krnl_partialknn_local_sp_2p_mem;

   localparam int NI = 4;
   localparam int DW = 64;
   localparam int AW = 4;
   localparam int NB = DW / 8;

   function automatic int cfg_rl(input int k);
      return k + 1;
   endfunction
   function automatic int cfg_byp(input int k);
      return k % 2;
   endfunction
   function automatic int cfg_ar(input int k);
      return (k == 3) ? 10 : 16;
   endfunction

   logic          clk;
   logic          reset;
   logic [AW-1:0] address0;
   logic          ce0;
   logic [AW-1:0] address1;
   logic [NB-1:0] we1;
   logic [DW-1:0] d1;
   logic [DW-1:0] q0 [NI];
   logic          q0_valid [NI];

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         krnl_partialknn_local_sp_2p_mem #(
            .DataWidth    (DW),
            .AddressRange (cfg_ar(gi)),
            .AddressWidth (AW),
            .ReadLatency  (cfg_rl(gi)),
            .Bypass       (cfg_byp(gi))
         ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .address0 (address0),
            .ce0      (ce0),
            .q0       (q0[gi]),
            .q0_valid (q0_valid[gi]),
            .address1 (address1),
            .we1      (we1),
            .d1       (d1)
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            inst;
      int            due;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           pend_q [$];
   logic [DW-1:0] mem_m [NI][16];
   logic [DW-1:0] exp_q0 [NI];
   logic          exp_valid [NI];
   int            issued [NI];
   int            seen [NI];
   int            cyc;
   int            vectors;
   int            miscompares;

   // Model one rising edge from the currently driven inputs, then advance past it.
   task automatic tick();
      rd_t           keep_q [$];
      logic [DW-1:0] word;
      logic          wr;
      for (int k = 0; k < NI; k++) begin
         word = '0;
         wr = reset && (we1 != '0) && (int'(address1) < cfg_ar(k));
         if (int'(address0) < cfg_ar(k)) begin
            word = mem_m[k][address0];
            if (wr && (address0 == address1) && (cfg_byp(k) == 1)) begin
               for (int b = 0; b < NB; b++) begin
                  if (we1[b]) word[b*8 +: 8] = d1[b*8 +: 8];
               end
            end
         end
         if (reset && ce0) begin
            pend_q.push_back('{k, cyc + cfg_rl(k), word});
            issued[k]++;
         end
         if (wr) begin
            for (int b = 0; b < NB; b++) begin
               if (we1[b]) mem_m[k][address1][b*8 +: 8] = d1[b*8 +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NI; k++) exp_valid[k] = 1'b0;
      foreach (pend_q[i]) begin
         if (pend_q[i].due == cyc) begin
            exp_valid[pend_q[i].inst] = 1'b1;
            exp_q0[pend_q[i].inst]    = pend_q[i].data;
         end else begin
            keep_q.push_back(pend_q[i]);
         end
      end
      pend_q = keep_q;
   endtask

   task automatic test_reset();
      reset = 1'b0; ce0 = 1'b0; we1 = '0; address0 = '0; address1 = '0; d1 = '0;
      repeat (3) tick();
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (q0[k] !== '0 || q0_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset inst%0d: q0=%h valid=%b, required q0=0 valid=0", k, q0[k], q0_valid[k]);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_fill();
      for (int a = 0; a < 16; a++) begin
         address1 = AW'(a); we1 = '1; d1 = {$urandom, $urandom};
         tick();
      end
      we1 = '0;
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (q0_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_no_strobe inst%0d: valid=%b, required 0", k, q0_valid[k]);
         end
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] aa;
      aa = {NB{8'hAA}};
      address1 = 4'd5; d1 = aa; we1 = '1; ce0 = 1'b0;
      tick();
      we1 = '0; address0 = 4'd5;
      for (int e = 1; e <= 3; e++) begin
         ce0 = (e == 1);
         tick();
         vectors++;
         if (q0_valid[1] !== (e == 2)) begin
            miscompares++;
            $display("FAIL write_read_strobe edge%0d: valid=%b, required %b", e, q0_valid[1], (e == 2));
         end
         if (e >= 2) begin
            vectors++;
            if (q0[1] !== aa) begin
               miscompares++;
               $display("FAIL write_read_data edge%0d: q0=%h, required %h", e, q0[1], aa);
            end
         end
         if (e == 1) begin
            vectors++;
            if (q0_valid[0] !== 1'b1 || q0[0] !== aa) begin
               miscompares++;
               $display("FAIL write_read_lat1: valid=%b q0=%h, required 1 %h", q0_valid[0], q0[0], aa);
            end
         end
      end
      ce0 = 1'b0;
   endtask

   task automatic test_byte_write();
      logic [DW-1:0] want;
      want = 64'h1111_1111_1111_11FF;
      address1 = 4'd7; d1 = {NB{8'h11}}; we1 = '1; ce0 = 1'b0;
      tick();
      d1 = '1; we1 = NB'(1);
      tick();
      we1 = '0; ce0 = 1'b1; address0 = 4'd7;
      tick();
      ce0 = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (q0[k] !== want) begin
            miscompares++;
            $display("FAIL byte_write inst%0d: q0=%h, required %h", k, q0[k], want);
         end
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] fives;
      logic [DW-1:0] want;
      fives = {NB{8'h55}};
      address1 = 4'd9; d1 = '0; we1 = '1; ce0 = 1'b0;
      tick();
      for (int e = 1; e <= 5; e++) begin
         ce0 = (e <= 2); address0 = 4'd9; address1 = 4'd9; d1 = fives;
         we1 = (e == 1) ? '1 : '0;
         tick();
         for (int k = 0; k < NI; k++) begin
            if (e == cfg_rl(k) || e == cfg_rl(k) + 1) begin
               want = (e == cfg_rl(k) && cfg_byp(k) == 0) ? '0 : fives;
               vectors++;
               if (q0_valid[k] !== 1'b1 || q0[k] !== want) begin
                  miscompares++;
                  $display("FAIL collision inst%0d edge%0d: valid=%b q0=%h, required 1 %h",
                           k, e, q0_valid[k], q0[k], want);
               end
            end
         end
      end
      ce0 = 1'b0; we1 = '0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] want;
      int            strobes;
      strobes = 0;
      address1 = 4'd12; d1 = {$urandom, $urandom}; we1 = '1; ce0 = 1'b0;
      tick();
      we1 = '0;
      for (int e = 1; e <= 20; e++) begin
         ce0 = (e <= 16);
         address0 = AW'(e - 1);
         tick();
         if (q0_valid[3] === 1'b1) strobes++;
         if (e >= 4 && e <= 19) begin
            want = ((e - 4) < 10) ? mem_m[3][e - 4] : '0;
            vectors++;
            if (q0_valid[3] !== 1'b1 || q0[3] !== want) begin
               miscompares++;
               $display("FAIL b2b addr%0d: valid=%b q0=%h, required 1 %h", e - 4, q0_valid[3], q0[3], want);
            end
         end
         for (int k = 0; k < NI; k++) begin
            vectors++;
            if (q0_valid[k] !== exp_valid[k] || q0[k] !== exp_q0[k]) begin
               miscompares++;
               $display("FAIL b2b_model inst%0d edge%0d: valid=%b q0=%h, required %b %h",
                        k, e, q0_valid[k], q0[k], exp_valid[k], exp_q0[k]);
            end
         end
      end
      vectors++;
      if (strobes !== 16) begin
         miscompares++;
         $display("FAIL b2b_count: strobes=%0d, required 16", strobes);
      end
   endtask

   task automatic test_reset_inflight();
      logic [DW-1:0] saved [NI];
      for (int k = 0; k < NI; k++) saved[k] = mem_m[k][3];
      for (int i = 1; i <= 3; i++) begin
         ce0 = 1'b1; address0 = AW'(i);
         tick();
      end
      ce0 = 1'b0;
      #2;
      reset = 1'b0;
      pend_q.delete();
      for (int k = 0; k < NI; k++) begin
         exp_q0[k] = '0; exp_valid[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (q0[k] !== '0 || q0_valid[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_immediate inst%0d: q0=%h valid=%b, required 0 0", k, q0[k], q0_valid[k]);
         end
      end
      ce0 = 1'b1; address0 = 4'd3; address1 = 4'd3; we1 = '1; d1 = {$urandom, $urandom};
      repeat (2) tick();
      reset = 1'b1; ce0 = 1'b0; we1 = '0;
      for (int e = 0; e < 5; e++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            vectors++;
            if (q0_valid[k] !== 1'b0 || q0[k] !== '0) begin
               miscompares++;
               $display("FAIL reset_discard inst%0d edge%0d: valid=%b q0=%h, required 0 0",
                        k, e, q0_valid[k], q0[k]);
            end
         end
      end
      for (int e = 0; e < 8; e++) begin
         ce0 = (e < 3); address0 = AW'(e + 1);
         tick();
      end
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (q0[k] !== saved[k]) begin
            miscompares++;
            $display("FAIL reset_retain inst%0d: q0=%h, required %h", k, q0[k], saved[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < NI; k++) begin
         issued[k] = 0; seen[k] = 0;
      end
      for (int n = 0; n < 405; n++) begin
         if (n < 400) begin
            ce0 = ($urandom_range(0, 3) != 0);
            address0 = AW'($urandom_range(0, 15));
            address1 = ($urandom_range(0, 3) == 0) ? address0 : AW'($urandom_range(0, 15));
            we1 = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
            d1 = {$urandom, $urandom};
         end else begin
            ce0 = 1'b0; we1 = '0;
         end
         tick();
         for (int k = 0; k < NI; k++) begin
            if (q0_valid[k] === 1'b1) seen[k]++;
            vectors++;
            if (q0_valid[k] !== exp_valid[k] || q0[k] !== exp_q0[k]) begin
               miscompares++;
               $display("FAIL random inst%0d cycle%0d: valid=%b q0=%h, required %b %h",
                        k, n, q0_valid[k], q0[k], exp_valid[k], exp_q0[k]);
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (seen[k] !== issued[k]) begin
            miscompares++;
            $display("FAIL random_count inst%0d: strobes=%0d, required %0d", k, seen[k], issued[k]);
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0;
      for (int k = 0; k < NI; k++) begin
         exp_q0[k] = '0; exp_valid[k] = 1'b0; issued[k] = 0; seen[k] = 0;
         for (int a = 0; a < 16; a++) mem_m[k][a] = '0;
      end
      test_reset();
      test_fill();
      test_write_read();
      test_byte_write();
      test_collision();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
